// File: rtl/serial_matrix_stream_decoder.sv
// serial_matrix_stream_decoder
// Assembles a DIM x DIM complex matrix from a serial stream of signed cells
// into one of two banks, then presents it to the consumer with a done/ack
// handshake. One bank fills while the other is presented.
module serial_matrix_stream_decoder #(
  parameter int NUMBER_BITS = 37,
  parameter int DIM         = 2,
  parameter int IDX_BITS    = 2 * $clog2(DIM) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [NUMBER_BITS-1:0] matrix_cell,
  input  logic                          ready,
  output logic                          accept,
  output logic signed [NUMBER_BITS-1:0] matrix [0:DIM-1][0:DIM-1][0:1],
  output logic                          done,
  input  logic                          ack,
  output logic                          overrun,
  output logic [15:0]                   matrices_loaded
);

  localparam int L = $clog2(DIM);
  localparam logic [IDX_BITS-1:0] LAST_INDEX = IDX_BITS'(2 * DIM * DIM - 1);

  // ST_PEND: the fill bank is complete but the consumer still holds the
  // other bank, so no further cells can be taken.
  typedef enum logic {ST_FILL, ST_PEND} fill_state_e;

  fill_state_e             state_q, state_d;
  logic [IDX_BITS-1:0]     fill_index_q, fill_index_d;
  logic                    fill_sel_q, fill_sel_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;
  logic [15:0]             count_q, count_d;

  logic signed [NUMBER_BITS-1:0] bank_q [0:1][0:DIM-1][0:DIM-1][0:1];
  logic signed [NUMBER_BITS-1:0] bank_d [0:1][0:DIM-1][0:DIM-1][0:1];

  logic [L-1:0] wr_row;
  logic [L-1:0] wr_col;
  logic         wr_im;
  logic         take;
  logic         ack_seen;
  logic         out_sel;

  // Cell index is {row, col, re/im}, so the write address is a bit split.
  assign wr_row   = fill_index_q[IDX_BITS-1 -: L];
  assign wr_col   = fill_index_q[L -: L];
  assign wr_im    = fill_index_q[0];

  assign accept   = (state_q != ST_PEND);
  assign take     = ready && accept;
  assign ack_seen = done_q && ack;
  assign out_sel  = ~fill_sel_q;

  assign done            = done_q;
  assign overrun         = overrun_q;
  assign matrices_loaded = count_q;

  // Next-state: cell capture, bank swap on completion or ack, done handshake.
  always_comb begin
    state_d      = state_q;
    fill_index_d = fill_index_q;
    fill_sel_d   = fill_sel_q;
    done_d       = done_q;
    overrun_d    = overrun_q;
    count_d      = count_q;
    bank_d       = bank_q;

    if (ready && !accept) begin
      overrun_d = 1'b1;
    end

    if (state_q == ST_PEND) begin
      if (ack_seen) begin
        fill_sel_d   = ~fill_sel_q;
        state_d      = ST_FILL;
        fill_index_d = '0;
        count_d      = count_q + 16'd1;
      end
    end else begin
      if (take) begin
        bank_d[fill_sel_q][wr_row][wr_col][wr_im] = matrix_cell;
      end
      if (take && (fill_index_q == LAST_INDEX)) begin
        if (!done_q || ack) begin
          fill_sel_d   = ~fill_sel_q;
          done_d       = 1'b1;
          fill_index_d = '0;
          count_d      = count_q + 16'd1;
        end else begin
          state_d = ST_PEND;
        end
      end else begin
        if (take) begin
          fill_index_d = fill_index_q + IDX_BITS'(1);
        end
        if (ack_seen) begin
          done_d = 1'b0;
        end
      end
    end
  end

  // Control registers; reset discards any partial or pending matrix.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FILL;
      fill_index_q <= '0;
      fill_sel_q   <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fill_index_q <= fill_index_d;
      fill_sel_q   <= fill_sel_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      count_q      <= count_d;
    end
  end

  // Matrix storage is deliberately left unreset; contents are only
  // meaningful once done has been raised.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  // The presented matrix is simply the bank not currently being filled.
  always_comb begin
    matrix = bank_q[out_sel];
  end

endmodule

// File: tb/tb_serial_matrix_stream_decoder.sv
// Directed testbench for serial_matrix_stream_decoder, covering DIM=2 and DIM=4.
module tb_serial_matrix_stream_decoder;

  localparam int NB = 37;

  logic clk = 1'b0;
  logic reset;

  logic signed [NB-1:0] a_cell, b_cell;
  logic a_ready, a_accept, a_done, a_ack, a_overrun;
  logic b_ready, b_accept, b_done, b_ack, b_overrun;
  logic [15:0] a_count, b_count;
  logic signed [NB-1:0] a_matrix [0:1][0:1][0:1];
  logic signed [NB-1:0] b_matrix [0:3][0:3][0:1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_matrix_stream_decoder #(.NUMBER_BITS(NB), .DIM(2)) dut_a (
    .clk(clk), .reset(reset), .matrix_cell(a_cell), .ready(a_ready),
    .accept(a_accept), .matrix(a_matrix), .done(a_done), .ack(a_ack),
    .overrun(a_overrun), .matrices_loaded(a_count)
  );

  serial_matrix_stream_decoder #(.NUMBER_BITS(NB), .DIM(4)) dut_b (
    .clk(clk), .reset(reset), .matrix_cell(b_cell), .ready(b_ready),
    .accept(b_accept), .matrix(b_matrix), .done(b_done), .ack(b_ack),
    .overrun(b_overrun), .matrices_loaded(b_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic signed [NB-1:0] v);
    a_ready = 1'b1;
    a_cell  = v;
    tick();
    a_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got=%b exp=0", a_done); end
    n_checks++; if (a_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun got=%b exp=0", a_overrun); end
    n_checks++; if (a_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_count got=%0d exp=0", a_count); end
    n_checks++; if (a_accept !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_accept got=%b exp=1", a_accept); end
  endtask

  task automatic test_single_load();
    for (int k = 0; k < 7; k++) send_a(NB'(k + 1));
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_done got=%b exp=0", a_done); end
    send_a(NB'(8));
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("[TB] FAIL single_done got=%b exp=1", a_done); end
    n_checks++; if (a_matrix[0][0][0] !== 37'sd1) begin n_fail++; $display("[TB] FAIL single_m000 got=%0d exp=1", a_matrix[0][0][0]); end
    n_checks++; if (a_matrix[0][1][1] !== 37'sd4) begin n_fail++; $display("[TB] FAIL single_m011 got=%0d exp=4", a_matrix[0][1][1]); end
    n_checks++; if (a_matrix[1][0][0] !== 37'sd5) begin n_fail++; $display("[TB] FAIL single_m100 got=%0d exp=5", a_matrix[1][0][0]); end
    n_checks++; if (a_matrix[1][1][1] !== 37'sd8) begin n_fail++; $display("[TB] FAIL single_m111 got=%0d exp=8", a_matrix[1][1][1]); end
    n_checks++; if (a_count !== 16'd1) begin n_fail++; $display("[TB] FAIL single_count got=%0d exp=1", a_count); end
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("[TB] FAIL single_ack_clear got=%b exp=0", a_done); end
  endtask

  task automatic test_pending_and_overrun();
    for (int k = 0; k < 8; k++) send_a(NB'(k + 1));
    n_checks++; if (a_count !== 16'd2) begin n_fail++; $display("[TB] FAIL pend_countA got=%0d exp=2", a_count); end
    for (int k = 0; k < 8; k++) send_a(NB'(k + 11));
    n_checks++; if (a_accept !== 1'b0) begin n_fail++; $display("[TB] FAIL pend_accept got=%b exp=0", a_accept); end
    n_checks++; if (a_matrix[0][0][0] !== 37'sd1) begin n_fail++; $display("[TB] FAIL pend_holdA got=%0d exp=1", a_matrix[0][0][0]); end
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("[TB] FAIL pend_done got=%b exp=1", a_done); end
    send_a(NB'(99));
    n_checks++; if (a_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_set got=%b exp=1", a_overrun); end
    n_checks++; if (a_matrix[1][1][1] !== 37'sd8) begin n_fail++; $display("[TB] FAIL ovr_holdA got=%0d exp=8", a_matrix[1][1][1]); end
    n_checks++; if (a_accept !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_accept got=%b exp=0", a_accept); end
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    n_checks++; if (a_matrix[0][0][0] !== 37'sd11) begin n_fail++; $display("[TB] FAIL swap_m000 got=%0d exp=11", a_matrix[0][0][0]); end
    n_checks++; if (a_matrix[1][1][1] !== 37'sd18) begin n_fail++; $display("[TB] FAIL swap_m111 got=%0d exp=18", a_matrix[1][1][1]); end
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("[TB] FAIL swap_done got=%b exp=1", a_done); end
    n_checks++; if (a_accept !== 1'b1) begin n_fail++; $display("[TB] FAIL swap_accept got=%b exp=1", a_accept); end
    n_checks++; if (a_count !== 16'd3) begin n_fail++; $display("[TB] FAIL swap_count got=%0d exp=3", a_count); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      a_ack = (k == 7);
      send_a(NB'(k + 21));
      n_checks++; if (a_accept !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_accept cell=%0d got=%b exp=1", k, a_accept); end
    end
    a_ack = 1'b0;
    n_checks++; if (a_matrix[0][0][0] !== 37'sd21) begin n_fail++; $display("[TB] FAIL b2b_m000 got=%0d exp=21", a_matrix[0][0][0]); end
    n_checks++; if (a_matrix[1][0][1] !== 37'sd26) begin n_fail++; $display("[TB] FAIL b2b_m101 got=%0d exp=26", a_matrix[1][0][1]); end
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done got=%b exp=1", a_done); end
    n_checks++; if (a_count !== 16'd4) begin n_fail++; $display("[TB] FAIL b2b_count got=%0d exp=4", a_count); end
    n_checks++; if (a_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_overrun_sticky got=%b exp=1", a_overrun); end
  endtask

  task automatic test_reset_midload();
    for (int k = 0; k < 5; k++) send_a(NB'(k + 31));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_done got=%b exp=0", a_done); end
    n_checks++; if (a_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_overrun got=%b exp=0", a_overrun); end
    n_checks++; if (a_count !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_count got=%0d exp=0", a_count); end
    for (int k = 0; k < 8; k++) send_a(NB'(k + 41));
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_reload_done got=%b exp=1", a_done); end
    n_checks++; if (a_matrix[0][0][0] !== 37'sd41) begin n_fail++; $display("[TB] FAIL rst_reload_m000 got=%0d exp=41", a_matrix[0][0][0]); end
    n_checks++; if (a_matrix[1][1][1] !== 37'sd48) begin n_fail++; $display("[TB] FAIL rst_reload_m111 got=%0d exp=48", a_matrix[1][1][1]); end
    n_checks++; if (a_count !== 16'd1) begin n_fail++; $display("[TB] FAIL rst_reload_count got=%0d exp=1", a_count); end
  endtask

  task automatic test_dim4_gaps();
    for (int k = 0; k < 32; k++) begin
      if (k % 3 == 0) begin
        b_ready = 1'b0;
        tick();
      end
      if (k == 31) begin
        n_checks++; if (b_done !== 1'b0) begin n_fail++; $display("[TB] FAIL d4_early_done got=%b exp=0", b_done); end
      end
      b_ready = 1'b1;
      b_cell  = NB'(k - 16);
      tick();
      b_ready = 1'b0;
    end
    n_checks++; if (b_done !== 1'b1) begin n_fail++; $display("[TB] FAIL d4_done got=%b exp=1", b_done); end
    n_checks++; if (b_matrix[0][0][0] !== -37'sd16) begin n_fail++; $display("[TB] FAIL d4_m000 got=%0d exp=-16", b_matrix[0][0][0]); end
    n_checks++; if (b_matrix[1][2][0] !== -37'sd4) begin n_fail++; $display("[TB] FAIL d4_m120 got=%0d exp=-4", b_matrix[1][2][0]); end
    n_checks++; if (b_matrix[3][3][1] !== 37'sd15) begin n_fail++; $display("[TB] FAIL d4_m331 got=%0d exp=15", b_matrix[3][3][1]); end
    n_checks++; if (b_count !== 16'd1) begin n_fail++; $display("[TB] FAIL d4_count got=%0d exp=1", b_count); end
  endtask

  initial begin
    reset   = 1'b1;
    a_ready = 1'b0; a_cell = '0; a_ack = 1'b0;
    b_ready = 1'b0; b_cell = '0; b_ack = 1'b0;
    test_reset();
    test_single_load();
    test_pending_and_overrun();
    test_back_to_back();
    test_reset_midload();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    test_dim4_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_matrix_stream_decoder.md
# serial_matrix_stream_decoder

Parametrised, double-buffered successor to the single-shot serial matrix decoder. It assembles a DIM×DIM complex gate matrix from a serial stream of signed cells and presents the completed matrix to the downstream gate-application stage. A second matrix can load while the consumer still holds the previous one, and a done/ack handshake plus flow control replaces the one-shot done latch. It sits between the host cell stream and the compiler's matrix-multiply datapath.

## Interface
- NUMBER_BITS, 37, signed width of one real or imaginary component
- DIM, 2, matrix dimension; power of two, 2..8 (2^qubits)
- IDX_BITS, derived 2·log2(DIM)+1, width of the cell index {row, col, re/im}
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- matrix_cell  input  NUMBER_BITS signed  incoming cell value
- ready  input  1  matrix_cell valid this cycle
- accept  output  1  decoder can take a cell this cycle (combinational)
- matrix  output  signed [NUMBER_BITS-1:0] [0:DIM-1][0:DIM-1][0:1]  presented matrix; index [row][col][REAL=0/IMAG=1]
- done  output  1  matrix holds a complete matrix
- ack  input  1  consumer has taken matrix; sampled only when done=1
- overrun  output  1  sticky: a cell was offered while accept=0
- matrices_loaded  output  16  count of matrices completed, wraps at 2^16

## Operation
- Two banks: FILL and OUT. Cells write into FILL at index {r,c,i}, row-major, real before imaginary, i.e. cell k → r=k>>(L+1), c=(k>>1)&(DIM-1), i=k&1, with L=log2(DIM).
- A cell is taken when ready && accept. fill_index increments by 1. At the last cell (index 2·DIM²−1), FILL is complete.
- Completion handling on the completing edge:
  - If done=0 or ack=1, the banks swap. The filled bank becomes OUT, done=1, fill_index=0, and matrices_loaded increments.
  - Otherwise FILL enters PENDING. fill_index holds at the max value, and accept=0.
- Per-edge state transitions:
  - In PENDING, ack=1 swaps the banks. done stays 1, PENDING clears, fill_index=0, and accept returns to 1 on the next cycle.
  - With done=1, ack=1, and no pending or completing fill, done clears to 0.
  - ack is ignored when done=0.
- accept = !PENDING. Cells are accepted while done=1, up to one full matrix ahead.
- ready && !accept leaves state unchanged, drops the cell, and sets overrun. overrun clears only on reset.
- The swap is a bank-select toggle, not a copy. matrix is a mux of the OUT bank.
- Storage is not reset. matrix contents are undefined until the first done.

## Timing
- Reset values: done=0, overrun=0, matrices_loaded=0, fill_index=0, PENDING=0, accept=1. The bank select resets to bank 0 as FILL.
- Reset asserted mid-load or mid-pending discards partial and pending data. On the next cycle the block is ready for cell 0.
- Latency: with the last cell accepted at edge n, done=1 and the full matrix are visible after edge n, with no bubble.
- Minimum cadence: one cell per cycle, giving 2·DIM² cycles per matrix back-to-back when ack is prompt.
- ack and the last cell arriving on the same edge with done=1: the new matrix swaps straight to OUT and done stays 1. No PENDING is entered, and accept stays 1.
- While done=1, the OUT bank never changes except on an ack edge.
- matrices_loaded wraps from 65535 to 0.

## Test plan
- Reset, DIM=2, send cells 1..8 on consecutive cycles: done=1 after the 8th edge, matrix[0][0][0]=1, [0][1][1]=4, [1][1][1]=8, matrices_loaded=1.
- DIM=4, send 32 cells with values −16..15 and gaps in ready: done after the 32nd accepted cell, matrix[3][3][1]=15, [0][0][0]=−16.
- Load A (1..8) without ack, then load B (11..18):
  - matrix stays A and accept=0 after B's last cell.
  - Assert ack: matrix=B, done stays 1, accept=1 on the next cycle, matrices_loaded=2.
- With A presented, assert ack on the same cycle as B's last cell: matrix=B immediately, accept never drops.
- While PENDING, drive ready with value 99: overrun=1, matrix and bank contents unchanged. Then ack and load C: overrun remains 1 until reset.
- Assert reset after 5 cells of a load: done=0, overrun=0, matrices_loaded=0. A fresh 8-cell load lands with cell 0 at [0][0][0].
